// File: rtl/ac97_playback_sched_if.sv
// Upstream stereo sample stream into the playback scheduler (valid/ready).
interface ac97_playback_sched_if;
    logic        in_valid;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        in_ready;

    modport master (output in_valid, output in_left, output in_right, input in_ready);
    modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/ac97_playback_sched.sv
// Buffers upstream stereo samples and presents one per codec frame, changing
// PCM outputs only in the single cycle the codec latches them.
module ac97_playback_sched #(
    parameter int DEPTH         = 4,
    parameter bit UNDERRUN_ZERO = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    ac97_playback_sched_if.slave     up,
    input  logic                     accept,
    output logic [15:0]              pcm_left,
    output logic [15:0]              pcm_right,
    output logic                     frame_tick,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              underrun_cnt,
    input  logic                     clr_underrun
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          accept_dly_q, accept_dly_d;
    logic          frame_tick_q, frame_tick_d;
    logic [31:0]   held_q, held_d;
    logic [15:0]   urun_q, urun_d;

    logic          rise, empty, push, pop, underrun;
    logic [31:0]   nxt;

    // rise matches the codec's own one-pulse on its accept level
    assign rise     = accept & ~accept_dly_q;
    assign empty    = (count_q == '0);
    assign push     = up.in_valid & in_ready_q;
    assign pop      = rise & enable & ~empty;
    assign underrun = rise & enable & empty;

    always_comb begin
        nxt = '0;
        if (enable) begin
            if (!empty)
                nxt = mem_q[rd_ptr_q];
            else if (!UNDERRUN_ZERO)
                nxt = held_q;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (push) mem_d[wr_ptr_q] = {up.in_left, up.in_right};
        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        count_d      = count_q + LW'(push) - LW'(pop);
        // ready follows full only; a pop this cycle frees space next cycle
        in_ready_d   = (count_d != LW'(DEPTH));
        accept_dly_d = accept;
        frame_tick_d = rise;
        held_d       = rise ? nxt : held_q;
        urun_d       = urun_q;
        if (clr_underrun)
            urun_d = '0;
        else if (underrun && urun_q != 16'hFFFF)
            urun_d = urun_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            accept_dly_q <= 1'b0;
            frame_tick_q <= 1'b0;
            held_q       <= '0;
            urun_q       <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            accept_dly_q <= accept_dly_d;
            frame_tick_q <= frame_tick_d;
            held_q       <= held_d;
            urun_q       <= urun_d;
        end
    end

    assign {pcm_left, pcm_right} = rise ? nxt : held_q;
    assign up.in_ready           = in_ready_q;
    assign frame_tick            = frame_tick_q;
    assign fifo_level            = count_q;
    assign underrun_cnt          = urun_q;
endmodule

// File: tb/tb_ac97_playback_sched.sv
// Scoreboard bench: two instances (repeat-last and zero on underrun) share stimulus.
module tb_ac97_playback_sched;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk, reset_n, enable, in_valid, accept, clr_underrun;
    logic [15:0] in_left, in_right;
    logic [15:0] pcm_l0, pcm_r0, pcm_l1, pcm_r1, urun0, urun1;
    logic tick0, tick1;
    logic [LW-1:0] lvl0, lvl1;

    ac97_playback_sched_if u_if0 ();
    ac97_playback_sched_if u_if1 ();
    assign u_if0.in_valid = in_valid;
    assign u_if0.in_left  = in_left;
    assign u_if0.in_right = in_right;
    assign u_if1.in_valid = in_valid;
    assign u_if1.in_left  = in_left;
    assign u_if1.in_right = in_right;

    ac97_playback_sched #(.DEPTH(DEPTH), .UNDERRUN_ZERO(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up(u_if0.slave),
        .accept(accept), .pcm_left(pcm_l0), .pcm_right(pcm_r0),
        .frame_tick(tick0), .fifo_level(lvl0), .underrun_cnt(urun0),
        .clr_underrun(clr_underrun));

    ac97_playback_sched #(.DEPTH(DEPTH), .UNDERRUN_ZERO(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up(u_if1.slave),
        .accept(accept), .pcm_left(pcm_l1), .pcm_right(pcm_r1),
        .frame_tick(tick1), .fifo_level(lvl1), .underrun_cnt(urun1),
        .clr_underrun(clr_underrun));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] sb_q[$];
    logic [31:0] m_held0, m_held1;
    logic        m_acc_d, m_tick;
    logic [15:0] m_urun;

    function automatic logic [169:0] observed();
        return {u_if0.in_ready, lvl0, tick0, urun0, pcm_l0, pcm_r0,
                u_if1.in_ready, lvl1, tick1, urun1, pcm_l1, pcm_r1};
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_held0 = '0; m_held1 = '0; m_acc_d = 1'b0; m_tick = 1'b0; m_urun = '0;
    endtask

    // One cycle: drive, compare against the model, then advance model and clock.
    task automatic step(input string name, input logic v, input logic [31:0] d, input logic acc);
        logic rise, push, urun_ev, rdy;
        logic [31:0] n0, n1, p0, p1;
        logic [LW-1:0] lvl;
        logic [169:0] exp_v, got_v;
        in_valid = v; {in_left, in_right} = d; accept = acc;
        #1;
        rise    = acc & ~m_acc_d;
        lvl     = LW'(sb_q.size());
        rdy     = (sb_q.size() != DEPTH);
        push    = v & rdy;
        urun_ev = 1'b0;
        n0 = m_held0; n1 = m_held1;
        if (rise) begin
            if (!enable) begin
                n0 = '0; n1 = '0;
            end else if (sb_q.size() != 0) begin
                n0 = sb_q.pop_front(); n1 = n0;
            end else begin
                n1 = '0; urun_ev = 1'b1;
            end
        end
        p0 = rise ? n0 : m_held0;
        p1 = rise ? n1 : m_held1;
        exp_v = {rdy, lvl, m_tick, m_urun, p0, rdy, lvl, m_tick, m_urun, p1};
        got_v = observed();
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got_v, exp_v);
        end
        if (push) sb_q.push_back(d);
        m_held0 = p0; m_held1 = p1;
        m_tick  = rise;
        m_acc_d = acc;
        if (clr_underrun)                        m_urun = '0;
        else if (urun_ev && m_urun != 16'hFFFF) m_urun = m_urun + 16'd1;
        @(posedge clk); #1;
        cyc++;
    endtask

    // 32-cycle codec frame: accept high for 16 cycles, rise in cycle 0.
    task automatic frame(input string name, input int push_at, input logic clr_at_rise);
        for (int k = 0; k < 32; k++) begin
            clr_underrun = (k == 0) && clr_at_rise;
            step(name, k == push_at, $urandom, k < 16);
        end
        clr_underrun = 1'b0;
    endtask

    task automatic test_reset();
        logic [169:0] zero_v;
        zero_v = {1'b1, {LW{1'b0}}, 1'b0, 16'h0, 32'h0, 1'b1, {LW{1'b0}}, 1'b0, 16'h0, 32'h0};
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            accept = i[0];
            #1;
            checks++;
            if (observed() !== zero_v) begin
                failures++;
                $display("FAIL reset_hold i=%0d got=%h exp=%h", i, observed(), zero_v);
            end
        end
        accept = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step("reset_release", 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_steady_feed();
        step("feed_push", 1'b1, {16'h1111, 16'hAAAA}, 1'b0);
        step("feed_push", 1'b1, {16'h2222, 16'hBBBB}, 1'b0);
        step("feed_push", 1'b1, {16'h3333, 16'hCCCC}, 1'b0);
        for (int f = 0; f < 3; f++) frame("feed_frame", -1, 1'b0);
    endtask

    task automatic test_underrun();
        frame("underrun", -1, 1'b0);
        frame("underrun", -1, 1'b0);
        frame("underrun_clr", -1, 1'b1);
        frame("underrun_after_clr", -1, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < DEPTH + 2; i++)
            step("bp_push", 1'b1, {16'h5000 + 16'(i), 16'hA000 + 16'(i)}, 1'b0);
        frame("bp_release", -1, 1'b0);
        for (int f = 0; f < 3 * DEPTH; f++) frame("bp_wrap", 8, 1'b0);
    endtask

    task automatic test_mute();
        for (int g = 0; g < 2 * DEPTH && sb_q.size() != 0; g++) frame("mute_drain", -1, 1'b0);
        step("mute_push", 1'b1, {16'h7777, 16'h8888}, 1'b0);
        step("mute_push", 1'b1, {16'h9999, 16'h6666}, 1'b0);
        enable = 1'b0;
        for (int f = 0; f < 3; f++) frame("mute_off", -1, 1'b0);
        enable = 1'b1;
        frame("mute_resume", -1, 1'b0);
    endtask

    task automatic test_random_stream();
        for (int f = 0; f < 200; f++) frame("random_stream", 3, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; in_valid = 1'b0; accept = 1'b0;
        clr_underrun = 1'b0; in_left = '0; in_right = '0;
        model_reset();
        test_reset();
        test_steady_feed();
        test_underrun();
        test_backpressure();
        test_mute();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ac97_playback_sched.md
Name: ac97_playback_sched

Overview:
Playback scheduler between the music/synth datapath and the ac97_if codec wrapper. It buffers stereo samples from an upstream producer in a small FIFO using a valid/ready handshake. It presents exactly one sample per codec frame, timed so that PCM_Playback_Left/Right change only in the single cycle the codec latches them. It also handles underrun, mute and underrun statistics.

Parameters:
DEPTH, 4, FIFO depth in stereo samples; power of two, at least 2.
UNDERRUN_ZERO, 0, on underrun: 0 = repeat the last presented sample, 1 = present zero.

Ports:
clk  in  1  system clock; also drives the codec wrapper's ClkIn.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  0 = mute; zeros are presented and the FIFO is not popped.
in_valid  in  1  upstream sample valid.
in_left  in  16  upstream left sample, two's complement.
in_right  in  16  upstream right sample, two's complement.
in_ready  out  1  FIFO can accept a sample; equals ~full.
accept  in  1  the codec's PCM_Playback_Accept level.
pcm_left  out  16  connects to PCM_Playback_Left.
pcm_right  out  16  connects to PCM_Playback_Right.
frame_tick  out  1  one-cycle pulse in the cycle after each frame edge.
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
underrun_cnt  out  16  count of underruns; saturates at 16'hFFFF.
clr_underrun  in  1  synchronous clear of underrun_cnt.

Behaviour:
- Reset (reset_n=0, asynchronous): FIFO empty, held sample = 0, accept_d = 0, frame_tick = 0, underrun_cnt = 0, in_ready = 1, pcm_left = pcm_right = 0.
- Frame edge:
  - accept_d is accept registered.
  - rise = accept & ~accept_d, combinational. It is identical to the codec's internal one-pulse.
- Presentation:
  - pcm_* = rise ? next : held, where held is a 32-bit register.
  - held loads next at the clock edge ending the rise cycle.
  - Result: the new value is visible only during the rise cycle, is latched by the codec at that edge, and stays stable until the next rise.
  - pcm_* never changes in any other cycle.
- Selection of next on rise:
  - enable=1 and FIFO not empty: next = FIFO head; the head is popped at the same edge.
  - enable=1 and FIFO empty: this is an underrun.
    - next = held if UNDERRUN_ZERO=0; next = 0 if UNDERRUN_ZERO=1.
    - underrun_cnt increments, saturating at 16'hFFFF.
  - enable=0: next = 0; no pop; no underrun counted.
- FIFO:
  - Push when in_valid & in_ready.
  - in_ready is registered ~full and does not depend on a same-cycle pop.
  - Push and pop in the same cycle: level unchanged; the pushed data is not bypassed to the current rise.
  - A push into an empty FIFO during a rise cycle still counts as an underrun.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - fifo_level = write count minus read count.
- frame_tick = registered rise, one cycle later. Upstream may use it as a sample-rate strobe.
- clr_underrun has priority over a same-cycle increment; the result is 0.
- Upstream data changing while in_valid=1 and in_ready=0 is ignored; no handshake requirement is imposed on the producer beyond valid/ready.
- Reset asserted mid-frame: all state clears immediately and pcm_* goes to 0. After release, the first rise presents a sample under the normal rules, which is an underrun unless samples were pushed first.

Test Plan:
- Reset check: hold reset_n=0 while toggling accept -> pcm_*=0, in_ready=1, fifo_level=0, underrun_cnt=0; release -> all still 0 until first push.
- Steady feed: push (16'h1111,16'hAAAA), (16'h2222,16'hBBBB), (16'h3333,16'hCCCC); drive accept with period 32 cycles (high 16) -> pcm_* takes each value in order, changes only in rise cycles, frame_tick pulses once per frame, fifo_level decrements 3->0.
- Underrun: FIFO empty at rise with held=16'h3333/16'hCCCC -> UNDERRUN_ZERO=0 repeats that sample, UNDERRUN_ZERO=1 outputs 0/0; underrun_cnt +1 per empty rise. clr_underrun at the same cycle as an underrun -> underrun_cnt=0.
- Backpressure: push DEPTH+2 samples with no rise -> in_ready falls after DEPTH pushes, fifo_level=DEPTH, extra samples are not stored. One rise -> in_ready=1 one cycle later; order is preserved across pointer wrap over 3*DEPTH samples.
- Mute: enable=0 with 2 samples queued across 3 rises -> pcm_*=0, fifo_level stays 2, underrun_cnt unchanged. enable=1 -> next rise presents the first queued sample.
- Codec compliance: connect ac97_if with the same clk, feed random samples for 200 frames -> no "changing inputs at the wrong time" messages; audio.snd data matches the pushed sequence.
